// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state encoding and constants for the program counter controller
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC selection (jump > branch > sequential) with target alignment check
module pc_next
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] target;
  logic        redirect;

  always_comb begin
    target   = pc + PC_STEP;
    redirect = 1'b0;
    if (jump) begin
      target   = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      target   = branch_target;
      redirect = 1'b1;
    end
    // Sequential steps are always aligned; only redirected targets can trap.
    misaligned = redirect && (target[1:0] != 2'b00);
    next_pc    = misaligned ? TRAP_VECTOR : target;
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch/execute sequencer owning the PC register and retired-instruction counter
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_output,
  output logic        misalign_trap,
  output logic [31:0] retired_count
);

  pc_state_t   state, state_nxt;
  logic [31:0] pc_q, cnt_q, next_pc;
  logic        misaligned, retire, trap_q;

  pc_next #(.TRAP_VECTOR(TRAP_VECTOR)) u_pc_next (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc_q   <= RESET_VECTOR;
      cnt_q  <= 32'd0;
      trap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      trap_q <= retire && misaligned;
      if (retire) begin
        pc_q  <= next_pc;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        // The request is held through stall; stall only gates completion in EXEC.
        imem_req = 1'b1;
        if (imem_ack) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        retire      = exec_done && !stall;
        if (retire) state_nxt = ST_FETCH;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr     = pc_q;
  assign pc_output     = pc_q;
  assign retired_count = cnt_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed self-checking bench for pc_ctrl with a fetch-address scoreboard
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ack, exec_done, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, instr_valid, misalign_trap;
  logic [31:0] imem_addr, pc_output, retired_count;
  logic        w_req, w_valid, w_trap;
  logic [31:0] w_addr, w_pc, w_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] fetch_q[$];
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr_valid(instr_valid), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc_output(pc_output), .misalign_trap(misalign_trap),
    .retired_count(retired_count)
  );

  pc_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .instr_valid(w_valid), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc_output(w_pc), .misalign_trap(w_trap),
    .retired_count(w_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pop_fetch(input string tag);
    if (fetch_q.size() == 0) begin
      chk1({tag, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      exp_addr = fetch_q.pop_front();
      chk({tag, "_addr"}, imem_addr, exp_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
    step(); step();
    chk("rst_pc", pc_output, 32'h0);
    chk("rst_cnt", retired_count, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_trap", misalign_trap, 1'b0);
    chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);

    // Release: exactly one IDLE cycle, then fetches with zero-wait ack.
    rst_n = 1'b1; imem_ack = 1'b1; exec_done = 1'b1;
    fetch_q.push_back(32'h0); fetch_q.push_back(32'h4); fetch_q.push_back(32'h8);
    chk1("idle_req", imem_req, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk1("seq_fetch_req", imem_req, 1'b1);
      pop_fetch("seq");
      step();
      chk1("seq_exec_valid", instr_valid, 1'b1);
      chk1("seq_exec_req", imem_req, 1'b0);
      step();
      if (i == 0) begin
        chk("wrap_pc", w_pc, 32'h0);
        chk("wrap_addr", w_addr, 32'h0);
        chk("wrap_cnt", w_cnt, 32'h1);
        chk1("wrap_req", w_req, 1'b1);
        chk1("wrap_valid", w_valid, 1'b0);
        chk1("wrap_trap", w_trap, 1'b0);
      end
    end
    chk("seq_cnt", retired_count, 32'd3);
    chk("seq_pc", pc_output, 32'hC);

    // Delayed ack under stall: request held 4 FETCH cycles.
    imem_ack = 1'b0; stall = 1'b1; exec_done = 1'b0;
    chk1("dly_req1", imem_req, 1'b1);
    step(); chk1("dly_req2", imem_req, 1'b1);
    step(); chk1("dly_req3", imem_req, 1'b1);
    step(); chk1("dly_req4", imem_req, 1'b1);
    imem_ack = 1'b1;
    step();
    chk1("dly_exec_valid", instr_valid, 1'b1);
    chk1("dly_exec_req", imem_req, 1'b0);
    chk("dly_pc", pc_output, 32'hC);

    // Stall blocks completion in EXEC.
    imem_ack = 1'b0; exec_done = 1'b1;
    step(); chk1("stall_valid1", instr_valid, 1'b1); chk("stall_pc1", pc_output, 32'hC);
    step(); chk1("stall_valid2", instr_valid, 1'b1); chk("stall_cnt2", retired_count, 32'd3);
    stall = 1'b0;
    fetch_q.push_back(32'h10);
    step();
    pop_fetch("unstall");
    chk("unstall_cnt", retired_count, 32'd4);
    chk1("unstall_req", imem_req, 1'b1);

    // Redirects in FETCH must be ignored; jump beats branch in EXEC.
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
    imem_ack = 1'b1;
    step();
    chk("ignore_fetch_pc", pc_output, 32'h10);
    imem_ack = 1'b0;
    fetch_q.push_back(32'h40);
    step();
    pop_fetch("jump");
    chk1("jump_trap", misalign_trap, 1'b0);
    chk("jump_cnt", retired_count, 32'd5);

    // Misaligned branch target redirects to trap vector with one-cycle pulse.
    jump = 1'b0; branch_target = 32'h82; exec_done = 1'b0; imem_ack = 1'b1;
    step();
    chk("br_exec_pc", pc_output, 32'h40);
    imem_ack = 1'b0; exec_done = 1'b1;
    fetch_q.push_back(32'h100);
    step();
    pop_fetch("trap");
    chk1("trap_pulse", misalign_trap, 1'b1);
    chk("trap_cnt", retired_count, 32'd6);
    branch_taken = 1'b0; exec_done = 1'b0;
    step();
    chk1("trap_pulse_end", misalign_trap, 1'b0);
    chk1("trap_fetch_req", imem_req, 1'b1);

    // Reset mid-FETCH with an ack on the same edge.
    imem_ack = 1'b1; rst_n = 1'b0;
    step();
    chk1("midrst_req", imem_req, 1'b0);
    chk1("midrst_valid", instr_valid, 1'b0);
    chk("midrst_pc", pc_output, 32'h0);
    chk("midrst_cnt", retired_count, 32'h0);
    rst_n = 1'b1; imem_ack = 1'b0;
    step();
    chk1("midrst_idle_exit", imem_req, 1'b1);
    step();
    chk1("midrst_fetch_hold", imem_req, 1'b1);
    chk1("midrst_no_exec", instr_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, PC value loaded on a misaligned control transfer.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  hazard hold; freezes EXEC completion.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  32  fetch address; SHALL equal pc_output.
REQ-008 imem_ack  input  1  fetch complete; sampled only while imem_req=1.
REQ-009 instr_valid  output  1  fetched instruction valid to datapath.
REQ-010 exec_done  input  1  datapath finished current instruction.
REQ-011 branch_taken  input  1  conditional branch resolved taken.
REQ-012 branch_target  input  32  branch destination.
REQ-013 jump  input  1  unconditional jump.
REQ-014 jump_target  input  32  jump destination.
REQ-015 pc_output  output  32  current program counter.
REQ-016 misalign_trap  output  1  one-cycle pulse: misaligned target redirected to TRAP_VECTOR.
REQ-017 retired_count  output  32  instructions completed since reset.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, EXEC; IDLE is entered only from reset and exits to FETCH after exactly one cycle.
REQ-019 FETCH: imem_req=1; imem_req SHALL stay high until imem_ack, regardless of stall; on imem_ack=1 -> EXEC next cycle.
REQ-020 imem_ack arriving in the first FETCH cycle SHALL be accepted (zero-wait fetch = 1 FETCH cycle).
REQ-021 EXEC: instr_valid=1, imem_req=0; stall=1 SHALL block exec_done and hold state, pc_output and retired_count.
REQ-022 EXEC with exec_done=1 and stall=0: pc_output loads next PC, retired_count increments by 1, state -> FETCH, all on the same edge.
REQ-023 Next-PC priority: jump -> jump_target; else branch_taken -> branch_target; else pc_output+4.
REQ-024 Selected jump/branch target with bits [1:0] != 2'b00 SHALL load TRAP_VECTOR instead; misalign_trap=1 in the following cycle only; instruction still counts as retired.
REQ-025 pc_output+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); retired_count wraps to 0 past 32'hFFFF_FFFF.
REQ-026 jump, branch_taken and targets SHALL be ignored outside EXEC completion cycle.
REQ-027 Minimum instruction period: 2 cycles (1 FETCH + 1 EXEC).

Reset
REQ-028 rst_n=0 at a posedge SHALL force state=IDLE, pc_output=RESET_VECTOR, retired_count=0, imem_req=0, instr_valid=0, misalign_trap=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-FETCH with pending request (imem_req drops on that edge; late imem_ack ignored) and mid-EXEC.

Structure
REQ-030 Package pc_ctrl_pkg SHALL hold the state enum, PC_STEP=4, and default RESET_VECTOR/TRAP_VECTOR constants.
REQ-031 Combinational next-PC selection and alignment check SHALL be a sub-module pc_next; FSM, PC register and counter remain in pc_ctrl.

Verification
REQ-032 Reset release, ack immediate, exec_done each EXEC, 3 instructions -> imem_addr 0x0, 0x4, 0x8; retired_count=3; IDLE lasts 1 cycle.
REQ-033 imem_ack delayed 3 cycles with stall=1 throughout FETCH -> imem_req held 4 cycles, then EXEC; pc_output unchanged.
REQ-034 In EXEC, stall=1 for 2 cycles with exec_done=1 -> no update; stall=0 -> pc_output 0x4, retired_count+1.
REQ-035 jump=1 jump_target=0x40 and branch_taken=1 branch_target=0x80 same cycle -> pc_output=0x40; branch_target=0x82 alone -> pc_output=0x100, misalign_trap pulse 1 cycle.
REQ-036 RESET_VECTOR=0xFFFF_FFFC, one sequential retire -> pc_output=0x0000_0000.
REQ-037 rst_n=0 during FETCH with imem_req=1, imem_ack=1 on that edge -> IDLE, pc_output=RESET_VECTOR, retired_count=0.
